// File: rtl/dm_ctrl_wait_if.sv
// CPU data-port bundle between the pipeline and the wait-state data memory.
// The CPU drives the request side (master); the memory answers (slave).
interface dm_ctrl_wait_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output req, we, addr, funct3, din,
    input  dout, ready, busy, err
  );

  modport slave (
    input  req, we, addr, funct3, din,
    output dout, ready, busy, err
  );
endinterface

// File: rtl/dm_ctrl_wait.sv
// RV32 data memory with byte/halfword/word access, sign/zero-extended loads,
// a fixed number of wait states and a req/ready handshake for CPU stalls.
//
// state  | meaning
// S_IDLE | waiting for req; legality decided here, illegal accesses skip RAM
// S_WAIT | counting down wait states; RAM access on the edge where count is 0
// S_DONE | ready pulse for one cycle, err reported with it
module dm_ctrl_wait #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int WAIT   = 1
) (
  input  logic           clk,
  input  logic           rstn,
  dm_ctrl_wait_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  state_t state, state_next;

  logic [2:0]        cnt, cnt_next;
  logic              we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] din_q;
  logic              err_q;
  logic [DATA_W-1:0] dout_q;

  logic              accept;
  logic              illegal;
  logic              do_access;
  logic              ram_we;
  logic [3:0]        byte_en;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] shifted;
  logic [15:0]       half;

  logic [DATA_W-1:0] ram [2**ADDR_W];

  // Address bits above the array are ignored so addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  always_comb begin
    illegal = 1'b0;
    case (bus.funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = bus.addr[0];
      3'b010:  illegal = (bus.addr[1:0] != 2'b00);
      3'b100:  illegal = bus.we;
      3'b101:  illegal = bus.we | bus.addr[0];
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    do_access  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req) begin
          accept = 1'b1;
          if (illegal) begin
            state_next = S_DONE;
          end else begin
            cnt_next   = WAIT_CNT;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt != 3'd0) begin
          cnt_next = cnt - 3'd1;
        end else begin
          do_access  = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      f3_q   <= 3'd0;
      din_q  <= '0;
      err_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      if (accept) begin
        we_q   <= bus.we;
        addr_q <= bus.addr[ADDR_W+1:0];
        f3_q   <= bus.funct3;
        din_q  <= bus.din;
        err_q  <= illegal;
      end
      if (do_access && !we_q) begin
        dout_q <= load_val;
      end
    end
  end

  assign rdata   = ram[addr_q[ADDR_W+1:2]];
  assign shifted = rdata >> {addr_q[1:0], 3'b000};
  assign half    = addr_q[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_val = rdata;
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{half[15]}}, half};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, half};
      default: load_val = rdata;
    endcase
  end

  // Store data is replicated across lanes; byte_en picks the lanes that land.
  always_comb begin
    byte_en = 4'b1111;
    wdata   = din_q;
    case (f3_q[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_q[1:0];
        wdata   = {4{din_q[7:0]}};
      end
      2'b01: begin
        byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{din_q[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wdata   = din_q;
      end
    endcase
  end

  // state is reset asynchronously, so an aborted store never reaches the array.
  assign ram_we = do_access & we_q;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          ram[addr_q[ADDR_W+1:2]][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.dout  = dout_q;
  assign bus.ready = (state == S_DONE);
  assign bus.busy  = (state != S_IDLE);
  assign bus.err   = (state == S_DONE) & err_q;

endmodule

// File: doc/dm_ctrl_wait.md
Name: dm_ctrl_wait

Overview:
- Parametrised successor to the single-cycle word-only data memory.
- Adds RISC-V byte, halfword and word loads and stores, with sign or zero extension on loads.
- Adds a configurable wait-state count and a req/ready handshake, so the pipelined CPU can stall on memory.
- Sits between the CPU data port and its own internal RAM array, inside the top-level computer wrapper.

Parameters:
- ADDR_W, default 7: word-address bits. The internal array holds 2^ADDR_W words.
- DATA_W, default 32: word width. Fixed at 32 for RV32; other values are not supported.
- WAIT, default 1: extra wait cycles per access, legal range 0..7.

Ports:
- clk  in  1  CPU clock. All state updates on the rising edge.
- rstn  in  1  Reset: asynchronous and active-low.
- req  in  1  Access request. Sampled only in IDLE.
- we  in  1  1 = store, 0 = load. Sampled with req.
- addr  in  32  Byte address. Sampled with req.
- funct3  in  3  Access type. 000 = LB/SB, 001 = LH/SH, 010 = LW/SW, 100 = LBU, 101 = LHU.
- din  in  32  Store data, right-justified. Sampled with req.
- dout  out  32  Load result, extended to 32 bits.
- ready  out  1  One-cycle pulse: the access has completed.
- busy  out  1  High from the cycle after acceptance until ready, inclusive.
- err  out  1  Valid with ready: the access was misaligned or had an illegal funct3.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state = IDLE; ready = 0, busy = 0, err = 0, dout = 0; wait counter = 0.
  - RAM contents are not cleared.
  - Reset mid-access aborts it. A pending store is not written.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If req=1, latch we, addr, funct3 and din.
  - If the access is illegal, go to DONE with err_next = 1 and skip the RAM. Illegal means any of:
    - halfword access with addr[0] = 1;
    - word access with addr[1:0] != 0;
    - funct3 of 011, 110 or 111;
    - store with funct3 of 100 or 101.
  - Otherwise load counter = WAIT and go to WAIT.
  - req=0: stay in IDLE.
- WAIT:
  - If counter != 0, decrement it and stay.
  - If counter == 0, perform the RAM access on this edge and go to DONE.
  - Load: dout is registered from the RAM word and formatted (see below).
  - Store: byte-enable write to the RAM word.
- DONE: ready = 1 for exactly one cycle, err as latched, then go to IDLE.
- Latency:
  - Legal access: ready is asserted WAIT+2 cycles after the req edge. WAIT=0 gives 2 cycles.
  - Illegal access: ready is asserted 1 cycle after the req edge.
- req while busy is ignored; it is not queued. A new req can be accepted in the cycle after DONE.
- Word index is addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2).
- Byte lane:
  - Byte access uses lane addr[1:0].
  - Halfword access uses lane addr[1] (bytes 0-1 or bytes 2-3).
- Loads:
  - Selected lane is shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Stores:
  - Only the addressed byte lanes are modified. Other bytes are preserved.
  - SB writes din[7:0]; SH writes din[15:0].
- dout retention:
  - dout holds its value until the next legal load completes.
  - Stores and illegal accesses leave dout unchanged.
- err is 0 whenever ready = 0.
- RAM is inferred from a synchronous-write array. There is no read-during-write hazard, because only one access is ever in flight.

Test Plan:
1. Reset then SW: WAIT=1; SW addr=0x10, din=0xDEADBEEF. Then LW addr=0x10.
   -> ready exactly 3 cycles after each req edge; dout=0xDEADBEEF; err=0.
2. Byte lanes: SB addr=0x13 din=0x000000A5 over word 0x11223344. Then LB 0x13 and LBU 0x13.
   -> LB dout=0xFFFFFFA5; LBU dout=0x000000A5; LW 0x10 = 0xA5223344.
3. Halfword: SH addr=0x16 din=0x8001. Then LH 0x16 and LHU 0x16.
   -> LH dout=0xFFFF8001; LHU dout=0x00008001.
4. Misaligned access: LW addr=0x12, then SH addr=0x11.
   -> ready one cycle after req, err=1, RAM unchanged, dout unchanged.
   Illegal funct3 of 011 gives the same response.
5. Busy and wrap: issue req during busy.
   -> ignored; no second ready.
   ADDR_W=7: SW to 0x200 aliases 0x000, so LW 0x000 returns the stored value.
6. Abort: drop rstn in WAIT of SW 0x20 din=0x12345678.
   -> outputs 0 immediately (asynchronously); after release, LW 0x20 returns the old contents.
